rx_frame_collector: RTL

Serial-to-parallel frame buffer directly upstream of the receive-side deinterpolator. It accepts one complex interpolated sample per cycle over a valid/ready handshake and assembles INT_SAMPLES samples into a parallel register frame. It then presents the whole frame, held stable, on array outputs until the consumer acknowledges it. This turns the streamed front-end output into the parallel 128-sample view the resampling stage consumes.

---
 rtl/rx_sd_pkg.sv | 19 +
 rtl/rx_frame_ctrl.sv | 131 +++++++++++++
 rtl/rx_frame_collector.sv | 83 ++++++++
 3 files changed

// File: rtl/rx_sd_pkg.sv
// -----------------------------------------------------------------------------
// rx_sd_pkg
// Shared definitions for the receive-side sample/deinterpolator path:
//   - default sample width and frame length
//   - frame collector FSM state encoding
//   - width of the optional dropped-sample counter (RX_FRAME_OVF_CNT_EN)
// -----------------------------------------------------------------------------
package rx_sd_pkg;

  localparam int DATA_WIDTH_DEF  = 16;
  localparam int INT_SAMPLES_DEF = 128;
  localparam int OVF_CNT_W       = 16;

  typedef enum logic {
    FILL = 1'b0,
    HOLD = 1'b1
  } state_e;

endpackage : rx_sd_pkg

// File: rtl/rx_frame_ctrl.sv
// -----------------------------------------------------------------------------
// rx_frame_ctrl
// Control path of the frame collector: FILL/HOLD FSM, write index, one-hot
// write enable for the frame registers and overflow reporting.
// Optional feature macro: RX_FRAME_OVF_CNT_EN adds a saturating dropped-sample
// counter on o_ovf_cnt.
// Ports:
//   i_clk, i_rst_n   clock, asynchronous active-low reset
//   i_valid, i_sof   input sample handshake and start-of-frame marker
//   i_frame_ack      consumer acknowledge of a held frame
//   o_ready          FILL-state decode (sample accepted this cycle)
//   o_frame_valid    HOLD-state decode (frame complete and stable)
//   o_overflow       registered one-cycle pulse per dropped sample
//   o_we             one-hot write enable, one bit per frame entry
//   o_ovf_cnt        saturating dropped-sample count (macro only)
// -----------------------------------------------------------------------------
module rx_frame_ctrl
  import rx_sd_pkg::*;
#(
  parameter int INT_SAMPLES = INT_SAMPLES_DEF
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic                   i_valid,
  input  logic                   i_sof,
  input  logic                   i_frame_ack,
  output logic                   o_ready,
  output logic                   o_frame_valid,
  output logic                   o_overflow,
  output logic [INT_SAMPLES-1:0] o_we
`ifdef RX_FRAME_OVF_CNT_EN
  ,
  output logic [OVF_CNT_W-1:0]   o_ovf_cnt
`endif
);

  localparam int               IDX_W    = $clog2(INT_SAMPLES);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(INT_SAMPLES - 1);
  localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);
  localparam logic [IDX_W-1:0] IDX_ZERO = {IDX_W{1'b0}};

  state_e                 r_state;
  state_e                 w_state_nxt;
  logic [IDX_W-1:0]       r_wr_idx;
  logic [IDX_W-1:0]       w_idx_nxt;
  logic [INT_SAMPLES-1:0] w_we;
  logic                   r_overflow;
  logic                   w_drop;

  // A sample offered while not in FILL is dropped.
  assign w_drop = i_valid && (r_state == HOLD);

  // Next-state, write index and one-hot write enable.
  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_wr_idx;
    w_we        = {INT_SAMPLES{1'b0}};
    case (r_state)
      FILL: begin
        if (i_valid) begin
          if (i_sof) begin
            // Resync: restart at entry 0 regardless of the partial frame.
            w_we[0]   = 1'b1;
            w_idx_nxt = IDX_ONE;
          end else begin
            w_we[r_wr_idx] = 1'b1;
            if (r_wr_idx == IDX_LAST) begin
              w_idx_nxt   = IDX_ZERO;
              w_state_nxt = HOLD;
            end else begin
              w_idx_nxt   = r_wr_idx + IDX_ONE;
            end
          end
        end else begin
          w_idx_nxt   = r_wr_idx;
          w_state_nxt = FILL;
        end
      end
      HOLD: begin
        if (i_frame_ack) begin
          w_idx_nxt   = IDX_ZERO;
          w_state_nxt = FILL;
        end else begin
          w_idx_nxt   = r_wr_idx;
          w_state_nxt = HOLD;
        end
      end
      default: begin
        w_idx_nxt   = IDX_ZERO;
        w_state_nxt = FILL;
      end
    endcase
  end

  // State, write index and overflow pulse registers.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state    <= FILL;
      r_wr_idx   <= IDX_ZERO;
      r_overflow <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_wr_idx   <= w_idx_nxt;
      r_overflow <= w_drop;
    end
  end

`ifdef RX_FRAME_OVF_CNT_EN
  logic [OVF_CNT_W-1:0] r_ovf_cnt;

  // Saturating count of dropped samples; start-of-frame does not clear it.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_ovf_cnt <= {OVF_CNT_W{1'b0}};
    end else if (w_drop && (r_ovf_cnt != {OVF_CNT_W{1'b1}})) begin
      r_ovf_cnt <= r_ovf_cnt + OVF_CNT_W'(1);
    end else begin
      r_ovf_cnt <= r_ovf_cnt;
    end
  end

  assign o_ovf_cnt = r_ovf_cnt;
`endif

  // Status outputs decode the state register only, never the inputs.
  assign o_ready       = (r_state == FILL);
  assign o_frame_valid = (r_state == HOLD);
  assign o_overflow    = r_overflow;
  assign o_we          = w_we;

endmodule : rx_frame_ctrl

// File: rtl/rx_frame_collector.sv
// -----------------------------------------------------------------------------
// rx_frame_collector
// Serial-to-parallel frame buffer in front of the deinterpolator. Collects
// INT_SAMPLES complex samples over valid/ready and holds the parallel frame
// stable until acknowledged.
// Optional feature macro: RX_FRAME_OVF_CNT_EN adds output o_ovf_cnt.
// Ports:
//   i_clk, i_rst_n        clock, asynchronous active-low reset
//   i_valid, i_re, i_im   input sample
//   i_sof                 start-of-frame marker (qualified by i_valid)
//   o_ready               block accepts a sample this cycle
//   o_re, o_im            assembled frame, entry 0 first
//   o_frame_valid         frame complete and stable
//   i_frame_ack           consumer took the frame
//   o_overflow            one-cycle pulse per dropped sample
//   o_ovf_cnt             saturating dropped-sample count (macro only)
// -----------------------------------------------------------------------------
module rx_frame_collector
  import rx_sd_pkg::*;
#(
  parameter int DATA_WIDTH  = DATA_WIDTH_DEF,
  parameter int INT_SAMPLES = INT_SAMPLES_DEF
) (
  input  logic                         i_clk,
  input  logic                         i_rst_n,
  input  logic                         i_valid,
  input  logic signed [DATA_WIDTH-1:0] i_re,
  input  logic signed [DATA_WIDTH-1:0] i_im,
  input  logic                         i_sof,
  output logic                         o_ready,
  output logic signed [DATA_WIDTH-1:0] o_re [0:INT_SAMPLES-1],
  output logic signed [DATA_WIDTH-1:0] o_im [0:INT_SAMPLES-1],
  output logic                         o_frame_valid,
  input  logic                         i_frame_ack,
  output logic                         o_overflow
`ifdef RX_FRAME_OVF_CNT_EN
  ,
  output logic [OVF_CNT_W-1:0]         o_ovf_cnt
`endif
);

  logic [INT_SAMPLES-1:0]       w_we;
  logic signed [DATA_WIDTH-1:0] r_re [0:INT_SAMPLES-1];
  logic signed [DATA_WIDTH-1:0] r_im [0:INT_SAMPLES-1];

  rx_frame_ctrl #(
    .INT_SAMPLES (INT_SAMPLES)
  ) u_ctrl (
    .i_clk         (i_clk),
    .i_rst_n       (i_rst_n),
    .i_valid       (i_valid),
    .i_sof         (i_sof),
    .i_frame_ack   (i_frame_ack),
    .o_ready       (o_ready),
    .o_frame_valid (o_frame_valid),
    .o_overflow    (o_overflow),
    .o_we          (w_we)
`ifdef RX_FRAME_OVF_CNT_EN
    ,
    .o_ovf_cnt     (o_ovf_cnt)
`endif
  );

  for (genvar gi = 0; gi < INT_SAMPLES; gi++) begin : g_entry
    // Frame entry register; only written when its one-hot enable fires.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
        r_re[gi] <= {DATA_WIDTH{1'b0}};
        r_im[gi] <= {DATA_WIDTH{1'b0}};
      end else if (w_we[gi]) begin
        r_re[gi] <= i_re;
        r_im[gi] <= i_im;
      end else begin
        r_re[gi] <= r_re[gi];
        r_im[gi] <= r_im[gi];
      end
    end
  end

  assign o_re = r_re;
  assign o_im = r_im;

endmodule : rx_frame_collector
